mat_stream_packer: RTL and testbench
====================================

Name: mat_stream_packer

Overview:
- Collects a ROWS x COLS matrix of signed W-bit elements arriving serially in row-major order over a valid/ready stream.
- Presents the full matrix as one flattened bus with a valid/ready handshake.
- Sits directly upstream of the combinational matrix transpose stage. Its output layout matches that stage's input packing: element [0][0] in the MSBs, then [0][1], and so on, with [ROWS-1][COLS-1] in the LSBs.

Parameters:
- ROWS, 3, matrix row count (>=1)
- COLS, 2, matrix column count (>=1)
- W, 4, element width in bits (signed, two's complement)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  W  element value
- in_valid  in  1  in_data/in_last valid
- in_last  in  1  marks final element of a matrix
- in_ready  out  1  packer can accept an element
- out_mat  out  ROWS*COLS*W  packed matrix, row-major, element 0 at MSBs
- out_valid  out  1  out_mat holds a complete matrix
- out_ready  in  1  downstream accepts out_mat
- err  out  1  one-cycle pulse on framing error

Behaviour:
- N = ROWS*COLS. Index counter k is clog2(N) bits wide, minimum 1 bit.
- Reset (rst_n low, asynchronous): state=FILL, k=0, out_mat=0, out_valid=0, err=0. in_ready is combinational: high in FILL, so it is 1 once reset releases.
- State FILL:
  - in_ready=1, out_valid=0.
  - Input accept = in_valid & in_ready.
  - On accept, in_data is written to out_mat bits [(N-k)*W-1 -: W] and k increments.
- End of matrix: on an accept with k==N-1, next state is FULL and k=0.
  - out_valid=1 from the cycle after that accept.
  - Latency: last element in at edge t, out_valid high after edge t.
- State FULL:
  - in_ready=0, out_valid=1.
  - out_mat is stable and must not change while out_valid is high.
  - On out_valid & out_ready, next state is FILL and out_valid drops next cycle.
  - No same-cycle bypass: a new element can be accepted at the earliest one cycle after the output handshake. Throughput is one matrix per N+1 cycles with no stalls.
- Framing via in_last:
  - Early last: accept with in_last=1 and k<N-1. err pulses 1 next cycle. The partial matrix is discarded: k=0, state stays FILL, out_valid is not raised. Previously written out_mat bits are left as-is and are overwritten by the next fill.
  - Missing last: accept with k==N-1 and in_last=0. err pulses 1 next cycle, but the matrix completes and is presented normally.
  - N==1: every accept completes a matrix. in_last=0 gives a missing-last err.
- err is registered, high for exactly one cycle per offending accept, otherwise 0.
- in_data is accepted only under handshake. Values outside a handshake are ignored; in_valid may drop mid-matrix and the counter holds.
- Elements are stored bit-exact; there is no sign extension or arithmetic.
- Asserting rst_n low mid-fill or while FULL aborts immediately:
  - all outputs return to reset values asynchronously;
  - the pending matrix is lost.

Test Plan:
- Basic fill (ROWS=3,COLS=2,W=4), out_ready=1: stream 1,2,3,4,5,6 on consecutive cycles with in_last on 6 -> out_valid high one cycle after the 6 is accepted, out_mat=24'h123456. out_valid drops after the handshake; in_ready is low only during the FULL cycle.
- Negative values and backpressure: stream F,E,D,C,B,A (-1..-6) with out_ready=0 -> out_mat=24'hFEDCBA held stable and in_ready=0 for 10 cycles. Raising out_ready gives one handshake, then in_ready=1 on the next cycle.
- Input gaps: in_valid toggles 1,0,1,0... while streaming 1..6 -> same result 24'h123456. The counter advances only on accepts and no err is raised.
- Early last: send 7,8,9 with in_last on 9 -> err pulses once and there is no out_valid. Then send 1..6 with in_last on 6 -> out_mat=24'h123456.
- Missing last: send 1..6 with in_last never set -> err pulse in the same cycle out_valid rises, and out_mat=24'h123456 is delivered.
- Reset mid-operation: pull rst_n low after 3 accepts, then again while FULL -> out_valid=0, out_mat=0, err=0 immediately, without waiting for a clock edge. After release a fresh 6-element stream packs correctly.

Source files
------------

// File: rtl/mat_stream_packer.sv
// Serial-to-parallel matrix packer: gathers ROWS*COLS signed elements in row-major
// order and presents them as one flattened bus, element [0][0] in the MSBs.
module mat_stream_packer #(
    parameter int ROWS = 3,
    parameter int COLS = 2,
    parameter int W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [ROWS*COLS*W-1:0] out_mat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err
);

    localparam int N  = ROWS * COLS;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends combinationally on ready, and in_ready depends only on state.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [N*W-1:0] mat_q, mat_d;
    logic           err_q, err_d;
    logic           accept;
    logic           at_end;

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign out_mat   = mat_q;
    assign err       = err_q;

    assign accept = in_valid & in_ready;
    assign at_end = (k_q == KW'(N - 1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mat_d   = mat_q;
        err_d   = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    mat_d[(N - 1 - int'(k_q)) * W +: W] = in_data;
                    if (at_end) begin
                        // Missing in_last still completes the matrix, but is flagged.
                        state_d = FULL;
                        k_d     = '0;
                        err_d   = ~in_last;
                    end else if (in_last) begin
                        // Early last: drop the partial matrix; stale bits get overwritten later.
                        k_d   = '0;
                        err_d = 1'b1;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            k_q     <= '0;
            mat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mat_q   <= mat_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mat_stream_packer.sv
// Bench for mat_stream_packer: directed scenarios plus random traffic, scored against a
// frame-level model (element queue per matrix, expected-matrix queue).
module tb_mat_stream_packer;

    localparam int ROWS = 3;
    localparam int COLS = 2;
    localparam int W    = 4;
    localparam int N    = ROWS * COLS;
    localparam int MW   = N * W;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [MW-1:0] out_mat;
    logic          out_valid;
    logic          out_ready;
    logic          err;

    mat_stream_packer #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_mat   (out_mat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0]  frame[$];
    logic [MW-1:0] exp_q[$];
    logic          exp_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] pack_frame();
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[(N - 1 - i) * W +: W] = frame[i];
        return r;
    endfunction

    task automatic model_reset();
        frame.delete();
        exp_q.delete();
        exp_err = 1'b0;
    endtask

    // One cycle, entered and left at a negedge: check outputs, drive, update model.
    task automatic step(input logic v, input logic [W-1:0] d, input logic last, input logic ordy);
        logic full;
        full = (exp_q.size() != 0);
        check("in_ready", in_ready, !full);
        check("out_valid", out_valid, full);
        check("err", err, exp_err);
        if (full) check("out_mat", out_mat, exp_q[0]);
        in_valid  = v;
        in_data   = d;
        in_last   = last;
        out_ready = ordy;
        exp_err   = 1'b0;
        if (!full && v) begin
            frame.push_back(d);
            if (frame.size() == N) begin
                exp_q.push_back(pack_frame());
                frame.delete();
                exp_err = !last;
            end else if (last) begin
                frame.delete();
                exp_err = 1'b1;
            end
        end else if (full && ordy) begin
            void'(exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, ordy);
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_mat"}, out_mat, '0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic lst;
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_mat", out_mat, '0);
        check("rst_err", err, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1'b1);

        // Basic fill
        for (int i = 1; i <= N; i++) step(1'b1, W'(i), i == N, 1'b1);
        check("basic_mat", out_mat, 24'h123456);
        idle(2, 1'b1);

        // Negative values under backpressure
        for (int i = 1; i <= N; i++) step(1'b1, W'(16 - i), i == N, 1'b0);
        check("neg_mat", out_mat, 24'hFEDCBA);
        for (int i = 0; i < 10; i++) step(1'b1, 4'h7, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Input gaps
        for (int i = 1; i <= N; i++) begin
            step(1'b1, W'(i), i == N, 1'b1);
            if (i != N) step(1'b0, 4'h9, 1'b1, 1'b1);
        end
        check("gap_mat", out_mat, 24'h123456);
        idle(2, 1'b1);

        // Early last, then a good matrix
        step(1'b1, 4'h7, 1'b0, 1'b1);
        step(1'b1, 4'h8, 1'b0, 1'b1);
        step(1'b1, 4'h9, 1'b1, 1'b1);
        check("early_err", err, 1'b1);
        for (int i = 1; i <= N; i++) step(1'b1, W'(i), i == N, 1'b0);
        check("early_mat", out_mat, 24'h123456);
        idle(2, 1'b1);

        // Missing last
        for (int i = 1; i <= N; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        check("miss_err", err, 1'b1);
        check("miss_valid", out_valid, 1'b1);
        check("miss_mat", out_mat, 24'h123456);
        idle(2, 1'b1);

        // Reset mid-fill, reset while FULL, then a fresh stream
        for (int i = 1; i <= 3; i++) step(1'b1, W'(i + 8), 1'b0, 1'b1);
        async_reset_check("rst_fill");
        for (int i = 1; i <= N; i++) step(1'b1, W'(i + 9), i == N, 1'b0);
        async_reset_check("rst_full");
        for (int i = 1; i <= N; i++) step(1'b1, W'(i), i == N, 1'b0);
        check("post_rst_mat", out_mat, 24'h123456);
        idle(2, 1'b1);

        // Random traffic with occasional framing errors
        for (int c = 0; c < 3000; c++) begin
            if (frame.size() == N - 1) lst = ($urandom_range(0, 9) != 0);
            else lst = ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 9) < 7, W'($urandom), lst, $urandom_range(0, 1) == 1);
        end
        idle(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
